// File: rtl/data_memory_if.sv
// Bus between the datapath (master) and the data-memory stage (slave):
// address/control/store data going in, load data and error flag coming back.
interface data_memory_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] read_data;
  logic        access_error;

  modport master (
    output address, write_data, mem_write, mem_read, size, sign_ext,
    input  read_data, access_error
  );

  modport slave (
    input  address, write_data, mem_write, mem_read, size, sign_ext,
    output read_data, access_error
  );
endinterface

// File: rtl/data_memory.sv
// Single-cycle data memory: combinational byte/half/word loads, edge-committed stores.
// Optional committed-store counter enabled by defining DMEM_STORE_COUNT_EN.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic clk,
  input  logic reset,
  data_memory_if.slave bus
`ifdef DMEM_STORE_COUNT_EN
  ,
  output logic [31:0] store_count
`endif
);

  logic [31:0]          mem [DEPTH_WORDS];
  logic [ADDR_BITS-1:0] word_index;
  logic [31:0]          stored_word;
  logic [15:0]          lane_low;
  logic                 access_error;
  logic                 store_commit;
  logic [3:0]           byte_enable;
  logic [31:0]          lane_data;
  logic [31:0]          read_data;
  logic                 unused_address_bits;

  // Upper address bits are deliberately dropped so addresses alias.
  assign unused_address_bits = ^bus.address[31:ADDR_BITS+2];
  assign word_index          = bus.address[ADDR_BITS+1:2];
  assign stored_word         = mem[word_index];
  assign lane_low            = 16'(stored_word >> {bus.address[1:0], 3'b000});

  always_comb begin
    access_error = 1'b0;
    if (bus.mem_read || bus.mem_write) begin
      case (bus.size)
        2'b00:   access_error = 1'b0;
        2'b01:   access_error = bus.address[0];
        2'b10:   access_error = |bus.address[1:0];
        default: access_error = 1'b1;
      endcase
    end
  end

  assign store_commit = bus.mem_write && !access_error;

  // Replicate the store data across lanes so byte_enable alone picks the target.
  always_comb begin
    byte_enable = 4'b0000;
    lane_data   = 32'h0000_0000;
    case (bus.size)
      2'b00: begin
        byte_enable = 4'b0001 << bus.address[1:0];
        lane_data   = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        byte_enable = bus.address[1] ? 4'b1100 : 4'b0011;
        lane_data   = {2{bus.write_data[15:0]}};
      end
      2'b10: begin
        byte_enable = 4'b1111;
        lane_data   = bus.write_data;
      end
      default: begin
        byte_enable = 4'b0000;
        lane_data   = 32'h0000_0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (store_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) begin
          mem[word_index][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    read_data = 32'h0000_0000;
    if (bus.mem_read && !access_error) begin
      case (bus.size)
        2'b00:   read_data = bus.sign_ext ? {{24{lane_low[7]}}, lane_low[7:0]}
                                          : {24'h000000, lane_low[7:0]};
        2'b01:   read_data = bus.sign_ext ? {{16{lane_low[15]}}, lane_low}
                                          : {16'h0000, lane_low};
        2'b10:   read_data = stored_word;
        default: read_data = 32'h0000_0000;
      endcase
    end
  end

  assign bus.read_data    = read_data;
  assign bus.access_error = access_error;

`ifdef DMEM_STORE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_count <= 32'h0000_0000;
    end else if (store_commit) begin
      store_count <= store_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: hand-computed loads, stores, lane isolation,
// errors, read-during-write and asynchronous reset.
module tb_data_memory;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
`ifdef DMEM_STORE_COUNT_EN
  logic [31:0] store_count;
  logic [31:0] exp_count = 32'd0;
`endif

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_STORE_COUNT_EN
    ,
    .store_count (store_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's request at the falling edge, settle 1 time unit.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.size       = sz;
    bus.sign_ext   = sext;
    bus.address    = addr;
    bus.write_data = wdata;
    #1;
  endtask

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b10;
    bus.sign_ext = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0000, 32'h0);
    checkOutput("reset_lw_0", bus.read_data, 32'h0);
    checkOutput("reset_err_0", {31'b0, bus.access_error}, 32'h0);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_03FC, 32'h0);
    checkOutput("reset_lw_3fc", bus.read_data, 32'h0);
    checkOutput("reset_err_3fc", {31'b0, bus.access_error}, 32'h0);

    applyStimulus(0, 1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF);
`ifdef DMEM_STORE_COUNT_EN
    exp_count++;
`endif
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    checkOutput("lw_10", bus.read_data, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0410, 32'h0);
    checkOutput("lw_alias_410", bus.read_data, 32'hDEAD_BEEF);

    applyStimulus(0, 1, 2'b10, 0, 32'h0000_0020, 32'h1122_3344);
    applyStimulus(0, 1, 2'b00, 0, 32'h0000_0021, 32'h1234_56AA);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0);
    checkOutput("sb_lane1", bus.read_data, 32'h1122_AA44);
    applyStimulus(0, 1, 2'b01, 0, 32'h0000_0022, 32'hFFFF_BEEF);
    applyStimulus(1, 0, 2'b10, 1, 32'h0000_0020, 32'h0);
    checkOutput("sh_upper", bus.read_data, 32'hBEEF_AA44);
`ifdef DMEM_STORE_COUNT_EN
    exp_count += 3;
`endif

    applyStimulus(1, 0, 2'b00, 1, 32'h0000_0021, 32'h0);
    checkOutput("lb_21", bus.read_data, 32'hFFFF_FFAA);
    applyStimulus(1, 0, 2'b00, 0, 32'h0000_0021, 32'h0);
    checkOutput("lbu_21", bus.read_data, 32'h0000_00AA);
    applyStimulus(1, 0, 2'b00, 1, 32'h0000_0020, 32'h0);
    checkOutput("lb_20_pos", bus.read_data, 32'h0000_0044);
    applyStimulus(1, 0, 2'b00, 1, 32'h0000_0023, 32'h0);
    checkOutput("lb_23", bus.read_data, 32'hFFFF_FFBE);
    applyStimulus(1, 0, 2'b01, 1, 32'h0000_0022, 32'h0);
    checkOutput("lh_22", bus.read_data, 32'hFFFF_BEEF);
    applyStimulus(1, 0, 2'b01, 0, 32'h0000_0022, 32'h0);
    checkOutput("lhu_22", bus.read_data, 32'h0000_BEEF);
    applyStimulus(1, 0, 2'b01, 1, 32'h0000_0020, 32'h0);
    checkOutput("lh_20", bus.read_data, 32'hFFFF_AA44);

    applyStimulus(0, 1, 2'b10, 0, 32'h0000_0012, 32'h5555_5555);
    checkOutput("sw_misalign_err", {31'b0, bus.access_error}, 32'h1);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    checkOutput("sw_misalign_nochange", bus.read_data, 32'hDEAD_BEEF);
`ifdef DMEM_STORE_COUNT_EN
    checkOutput("count_after_err", store_count, exp_count);
`endif
    applyStimulus(1, 0, 2'b01, 1, 32'h0000_0021, 32'h0);
    checkOutput("lh_misalign_err", {31'b0, bus.access_error}, 32'h1);
    checkOutput("lh_misalign_data", bus.read_data, 32'h0);
    applyStimulus(1, 0, 2'b11, 0, 32'h0000_0020, 32'h0);
    checkOutput("size11_err", {31'b0, bus.access_error}, 32'h1);
    checkOutput("size11_data", bus.read_data, 32'h0);
    applyStimulus(0, 0, 2'b11, 0, 32'h0000_0021, 32'h0);
    checkOutput("idle_no_err", {31'b0, bus.access_error}, 32'h0);
    checkOutput("idle_data_zero", bus.read_data, 32'h0);

    applyStimulus(0, 1, 2'b10, 0, 32'h0000_0030, 32'h0000_0001);
    applyStimulus(1, 1, 2'b10, 0, 32'h0000_0030, 32'h0000_0002);
    checkOutput("rw_same_old", bus.read_data, 32'h0000_0001);
    @(posedge clk);
    #1;
    checkOutput("rw_same_new", bus.read_data, 32'h0000_0002);
`ifdef DMEM_STORE_COUNT_EN
    exp_count += 2;
    checkOutput("count_before_reset", store_count, exp_count);
`endif

    applyStimulus(1, 1, 2'b10, 0, 32'h0000_0030, 32'h0000_0099);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_data", bus.read_data, 32'h0);
`ifdef DMEM_STORE_COUNT_EN
    exp_count = 32'd0;
    checkOutput("reset_mid_count", store_count, exp_count);
`endif
    bus.address = 32'h0000_0031;
    #1;
    checkOutput("reset_err_live", {31'b0, bus.access_error}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.mem_write = 1'b0;
    reset = 1'b0;
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0030, 32'h0);
    checkOutput("store_lost", bus.read_data, 32'h0);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    checkOutput("cleared_10", bus.read_data, 32'h0);

    applyStimulus(0, 1, 2'b10, 0, 32'h0000_0040, 32'h0000_0005);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
    checkOutput("post_reset_store", bus.read_data, 32'h0000_0005);
`ifdef DMEM_STORE_COUNT_EN
    exp_count++;
    checkOutput("post_reset_count", store_count, exp_count);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
